flash_adc_encoder: RTL and testbench
====================================

Name: flash_adc_encoder

Overview:
Parametrised digital back-end for a flash ADC macro. Synchronises the raw comparator thermometer code and applies bubble correction. Encodes the result to binary and averages 2^AVG_LOG2 samples with rounding. Delivers results through a valid/ready output register in single-shot or continuous mode, and sits between the analog comparator bank and the user-side readout logic.

Parameters:
COMP_COUNT, 15, number of comparators (levels = COMP_COUNT+1)
OUT_W, clog2(COMP_COUNT+1), result width (derived, not overridden)
AVG_LOG2, 2, log2 of samples averaged per result (0 = no averaging)
SYNC_STAGES, 2, synchroniser flops on comparator inputs (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  block enable; low = synchronous abort to IDLE
comp_in  in  COMP_COUNT  raw comparator outputs, bit i = comparator i (asynchronous)
start  in  1  single-shot request, sampled in IDLE only
cont  in  1  continuous-conversion mode
clr_ovr  in  1  clears the overrun flag
sample  out  OUT_W  averaged result
sample_valid  out  1  result available
sample_ready  in  1  consumer accepts the result
busy  out  1  state != IDLE
overrun  out  1  sticky: result dropped
bubble_err  out  1  registered; high when correction changed the code this cycle

Behaviour:
- Reset values: sample=0, sample_valid=0, busy=0, overrun=0, bubble_err=0. Also clears the synchroniser, accumulator, counter and FSM (to IDLE). Reset overrides all other inputs.
- Synchroniser: comp_in passes through SYNC_STAGES flops to give t[].
- Bubble correction: c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[COMP_COUNT]=0. Neighbours are the raw synchronised bits.
- Encoding: code = popcount(c).
- bubble_err: registered (c != t), updated every cycle regardless of state.
- Accumulator width is OUT_W+AVG_LOG2. Result = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2; when AVG_LOG2=0 the result is acc. The result never exceeds COMP_COUNT.
- FSM states: IDLE, SETTLE, ACCUM.
  - IDLE -> SETTLE when en & (start | cont).
  - SETTLE lasts SYNC_STAGES cycles to flush stale synchroniser data, then -> ACCUM with acc=0.
  - ACCUM adds code each cycle for 2^AVG_LOG2 cycles. On the final edge the result is offered to the output register.
  - After ACCUM: -> ACCUM (acc cleared, no re-settle) if cont=1; otherwise -> IDLE.
- Latency: start sampled at edge 0 -> sample_valid high after edge 1+SYNC_STAGES+2^AVG_LOG2 (7 with defaults). Continuous mode then yields one result every 2^AVG_LOG2 cycles.
- Output register:
  - Loads when sample_valid=0, or when sample_valid=1 & sample_ready=1 on the same edge. The simultaneous case is a load with no overrun.
  - Otherwise the new result is discarded; sample and sample_valid are unchanged and overrun is set.
  - sample_valid clears on valid&ready when no new result arrives that edge.
  - sample is stable while sample_valid=1.
- overrun: sticky until clr_ovr=1 or rst. If set and clr_ovr happen on the same edge, overrun stays set.
- start while busy: ignored. Clearing cont mid-conversion: the current conversion completes, then -> IDLE.
- en=0 in any state: FSM -> IDLE next edge, accumulator cleared, no result produced. The output register and overrun are retained.

Test Plan:
- Reset: rst high 2 cycles mid-ACCUM with comp_in=0x7FFF -> after next edge, sample=0, sample_valid=0, busy=0, overrun=0, bubble_err=0.
- Single shot: comp_in=0x00FF, start pulse at edge 0 -> sample_valid rises after edge 7 with sample=8, busy=0 afterwards. Hold sample_ready=0 10 cycles -> sample stays 8, no overrun.
- Bubble: comp_in=0x005F -> corrected 0x003F, sample=6, bubble_err=1 throughout ACCUM. comp_in=0x003F -> bubble_err=0.
- Rounding: comp_in alternates 0x0007/0x000F each cycle (sum 14 over 4 samples) -> sample=4, not truncated 3. AVG_LOG2=0 build with 0x0007 -> sample=3.
- Continuous/overrun: cont=1, comp_in=0x0003, sample_ready=0 -> first result 2 valid. Next result 4 cycles later is dropped, overrun=1, sample=2. Assert sample_ready -> accepted. Same-edge valid/ready with a new result -> no new overrun. clr_ovr -> overrun=0.
- Abort: en=0 during ACCUM cycle 2 -> busy=0 next edge, no sample_valid, prior sample unchanged. Next start produces a full 7-cycle conversion.

Source files
------------

// File: rtl/flash_adc_encoder.sv
// rtl/flash_adc_encoder.sv - flash ADC back-end: synchronise, bubble-correct, encode, average
// Results leave through a single valid/ready register with a sticky overrun flag.
module flash_adc_encoder #(
    parameter int COMP_COUNT  = 15,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2,
    localparam int OUT_W      = $clog2(COMP_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [COMP_COUNT-1:0] comp_in,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  clr_ovr,
    output logic [OUT_W-1:0]      sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  bubble_err
);

    localparam int ACC_W   = OUT_W + AVG_LOG2;
    localparam int NAVG    = 1 << AVG_LOG2;
    localparam int CNT_MAX = (NAVG > SYNC_STAGES) ? NAVG : SYNC_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HALF    = (AVG_LOG2 > 0) ? (1 << ((AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0)) : 0;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc;
    logic [OUT_W-1:0]        res_data;
    logic                    res_pend;
    logic [COMP_COUNT-1:0]   sync_q [SYNC_STAGES];
    logic [COMP_COUNT-1:0]   t;
    logic [COMP_COUNT-1:0]   c;
    logic [COMP_COUNT+1:0]   ext;
    logic [OUT_W-1:0]        code;
    logic [ACC_W-1:0]        sum;
    logic [ACC_W-1:0]        rnd;
    logic [OUT_W-1:0]        res_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= comp_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign t = sync_q[SYNC_STAGES-1];

    // ext pads the thermometer with an implied 1 below and 0 above
    always_comb begin
        ext  = {1'b0, t, 1'b1};
        c    = '0;
        code = '0;
        for (int i = 0; i < COMP_COUNT; i++) begin
            c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        for (int i = 0; i < COMP_COUNT; i++) begin
            code = code + OUT_W'(c[i]);
        end
        sum      = acc + ACC_W'(code);
        rnd      = sum + ACC_W'(HALF);
        res_next = OUT_W'(rnd >> AVG_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            res_data     <= '0;
            res_pend     <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            bubble_err   <= 1'b0;
        end else begin
            bubble_err <= (c != t);
            res_pend   <= 1'b0;

            // a finished result reaches the output register one edge after the last add
            if (res_pend) begin
                if (!sample_valid || sample_ready) begin
                    sample       <= res_data;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (clr_ovr && !(res_pend && sample_valid && !sample_ready)) begin
                overrun <= 1'b0;
            end

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                acc   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start || cont) begin
                            state <= SETTLE;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt == CNT_W'(SYNC_STAGES - 1)) begin
                            state <= ACCUM;
                            cnt   <= '0;
                            acc   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ACCUM: begin
                        if (cnt == CNT_W'(NAVG - 1)) begin
                            res_data <= res_next;
                            res_pend <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            if (!cont) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_adc_encoder.sv
// tb/tb_flash_adc_encoder.sv - self-checking bench for flash_adc_encoder
module tb_flash_adc_encoder;

    localparam int N = 15;

    logic         clk = 1'b0;
    logic         rst, en, start, cont, clr_ovr, sample_ready;
    logic [N-1:0] comp_in;
    logic [3:0]   sample, sample0;
    logic         sample_valid, busy, overrun, bubble_err;
    logic         valid0, busy0, ovr0, bub0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    flash_adc_encoder dut (
        .clk(clk), .rst(rst), .en(en), .comp_in(comp_in), .start(start), .cont(cont),
        .clr_ovr(clr_ovr), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .overrun(overrun), .bubble_err(bubble_err)
    );

    flash_adc_encoder #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .comp_in(comp_in), .start(start), .cont(cont),
        .clr_ovr(clr_ovr), .sample(sample0), .sample_valid(valid0),
        .sample_ready(sample_ready), .busy(busy0), .overrun(ovr0), .bubble_err(bub0)
    );

    typedef struct {
        logic [N-1:0] comp;
        int           exp_sample;
        logic         exp_bubble;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
    endtask

    // majority vote over neighbours, with an implied 1 below bit 0 and 0 above the top bit
    function automatic logic [N-1:0] ref_fix(input logic [N-1:0] v);
        logic [N-1:0] r;
        int lo, mid, hi;
        for (int i = 0; i < N; i++) begin
            lo   = (i == 0) ? 1 : int'(v[i-1]);
            mid  = int'(v[i]);
            hi   = (i == N - 1) ? 0 : int'(v[i+1]);
            r[i] = (lo + mid + hi) >= 2;
        end
        return r;
    endfunction

    function automatic int ref_code(input logic [N-1:0] v);
        return $countones(ref_fix(v));
    endfunction

    function automatic logic [N-1:0] rand_comp();
        logic [15:0] th;
        th = (16'd1 << $urandom_range(0, 15)) - 16'd1;
        if ($urandom_range(0, 2) == 0) th[$urandom_range(0, 14)] ^= 1'b1;
        return th[N-1:0];
    endfunction

    task automatic run_shot(input logic [N-1:0] v, input int exp_s, input logic exp_b);
        drain();
        comp_in = v;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step_n(5);
        check("valid_early", sample_valid, 0);
        step();
        check("bubble_err", bubble_err, exp_b);
        step();
        check("valid_at_7", sample_valid, 1);
        check("sample", sample, exp_s);
        check("busy_done", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal;
    end

    initial begin
        logic [N-1:0] vals [8];
        int sum, lat;

        vecs[0] = '{15'h00FF, 8, 1'b0};
        vecs[1] = '{15'h005F, 6, 1'b1};
        vecs[2] = '{15'h003F, 6, 1'b0};
        vecs[3] = '{15'h7FFF, 15, 1'b0};
        vecs[4] = '{15'h0000, 0, 1'b0};
        vecs[5] = '{15'h0002, 1, 1'b1};
        vecs[6] = '{15'h4000, 0, 1'b1};
        vecs[7] = '{15'h7FFE, 15, 1'b1};
        vecs[8] = '{15'h0001, 1, 1'b0};

        rst = 1'b1; en = 1'b1; start = 1'b0; cont = 1'b0; clr_ovr = 1'b0;
        sample_ready = 1'b0; comp_in = '0;
        step_n(2);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_bubble", bubble_err, 0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) run_shot(vecs[k].comp, vecs[k].exp_sample, vecs[k].exp_bubble);

        run_shot(15'h00FF, 8, 1'b0);
        step_n(10);
        check("hold_sample", sample, 8);
        check("hold_valid", sample_valid, 1);
        check("hold_overrun", overrun, 0);

        drain();
        comp_in = 15'h0007;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            comp_in = (j % 2 == 1) ? 15'h000F : 15'h0007;
            step();
        end
        check("round_valid", sample_valid, 1);
        check("round_sample", sample, 4);

        run_shot(15'h0007, 3, 1'b0);
        check("avg0_valid", valid0, 1);
        check("avg0_sample", sample0, 3);

        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 8; j++) vals[j] = rand_comp();
            sum = 0;
            for (int j = 1; j <= 4; j++) sum += ref_code(vals[j]);
            drain();
            comp_in = vals[0];
            start   = 1'b1;
            step();
            start   = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                comp_in = vals[j];
                step();
                if (j >= 2) check("rnd_bubble", bubble_err, ref_fix(vals[j-2]) != vals[j-2]);
                if (j == 6) check("rnd_early", sample_valid, 0);
            end
            check("rnd_valid", sample_valid, 1);
            check("rnd_sample", sample, (sum + 2) / 4);
        end

        drain();
        comp_in = 15'h0003;
        cont    = 1'b1;
        step();
        step_n(6);
        check("cont_early", sample_valid, 0);
        step();
        check("cont_valid", sample_valid, 1);
        check("cont_sample", sample, 2);
        check("cont_ovr0", overrun, 0);
        step_n(4);
        check("drop_ovr", overrun, 1);
        check("drop_sample", sample, 2);
        check("drop_valid", sample_valid, 1);
        drain();
        check("accept_clears", sample_valid, 0);
        step_n(3);
        check("next_valid", sample_valid, 1);
        check("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("clr_ovr", overrun, 0);
        step_n(2);
        drain();
        check("same_edge_valid", sample_valid, 1);
        check("same_edge_no_ovr", overrun, 0);
        step_n(3);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("set_beats_clr", overrun, 1);
        cont = 1'b0;
        sample_ready = 1'b1;
        step_n(4);
        sample_ready = 1'b0;
        check("cont_off_valid", sample_valid, 1);
        check("cont_off_sample", sample, 2);
        check("cont_off_busy", busy, 0);
        step();
        check("cont_off_idle", busy, 0);

        drain();
        comp_in = 15'h7FFF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step_n(4);
        en = 1'b0;
        step();
        check("abort_busy", busy, 0);
        step_n(4);
        check("abort_valid", sample_valid, 0);
        check("abort_sample", sample, 2);
        check("abort_ovr_kept", overrun, 1);
        en = 1'b1;

        comp_in = 15'h00FF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        lat     = 0;
        while (!sample_valid && lat < 20) begin
            step();
            lat++;
        end
        check("restart_latency", lat, 7);
        check("restart_sample", sample, 8);

        comp_in = 15'h7FFF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step_n(4);
        rst = 1'b1;
        step_n(2);
        rst = 1'b0;
        check("midrst_sample", sample, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_bubble", bubble_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
